bd_tag_split: RTL and testbench

- Inverse of the BD/tag merge path: consumes one stream of unencoded BD words (payload plus leaf code) and demultiplexes it by leaf code.
- Words carrying the tag/count leaf code (30) are unpacked into a tag/ct channel. All other words go unchanged to a BD output channel.
- Each output has its own 2-entry skid buffer, so a stalled consumer on one branch does not block the other branch until that branch's buffer fills.
- Sits on the upstream path between the BD deserializer and the tag/count consumers.

---
 rtl/bd_tag_split.sv | 162 ++++++++++++++++
 tb/tb_bd_tag_split.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bd_tag_split.sv
// BD/tag split: demultiplexes an unencoded BD word stream by leaf code into a
// BD channel and an unpacked tag/ct channel, each behind its own 2-entry skid FIFO.

module bd_tag_split_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_v,
    input  logic [W-1:0] push_d,
    output logic         push_a,
    output logic         pop_v,
    output logic [W-1:0] pop_d,
    input  logic         pop_a
);
    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              full;
    logic              push;
    logic              pop;

    assign full   = cnt[1];
    assign pop_v  = |cnt;
    assign pop_d  = mem[rd_ptr];
    assign pop    = pop_v & pop_a;
    // A full FIFO still takes a word when its head leaves on the same edge.
    assign push_a = ~full | pop;
    assign push   = push_v & push_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_d;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module bd_tag_split_cnt #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [N-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && count != {N{1'b1}})
            count <= count + 1'b1;
    end
endmodule

module bd_tag_split #(
    parameter int NBDData   = 20,
    parameter int Ncode     = 6,
    parameter int Ntag      = 11,
    parameter int Nct       = 9,
    parameter int TagCtCode = 30,
    parameter int Ncnt      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_v,
    input  logic [NBDData-1:0] in_payload,
    input  logic [Ncode-1:0]   in_leaf_code,
    output logic               in_a,
    output logic               bd_out_v,
    output logic [NBDData-1:0] bd_out_payload,
    output logic [Ncode-1:0]   bd_out_leaf_code,
    input  logic               bd_out_a,
    output logic               tag_out_v,
    output logic [Ntag-1:0]    tag_out_tag,
    output logic [Nct-1:0]     tag_out_ct,
    input  logic               tag_out_a,
    input  logic               cnt_clear,
    output logic [Ncnt-1:0]    bd_count,
    output logic [Ncnt-1:0]    tag_count
);
    localparam logic [Ncode-1:0] TAG_CODE = Ncode'(TagCtCode);
    localparam int BD_W  = NBDData + Ncode;
    localparam int TAG_W = Ntag + Nct;

    generate
        if (NBDData != Ntag + Nct) begin : g_bad_width
            $error("bd_tag_split: NBDData must equal Ntag + Nct");
        end
    endgenerate

    logic             sel_tag;
    logic             bd_push_a;
    logic             tag_push_a;
    logic [BD_W-1:0]  bd_head;
    logic [TAG_W-1:0] tag_head;
    logic [1:0]       xfer;
    logic [1:0][Ncnt-1:0] cnt;

    assign sel_tag = (in_leaf_code == TAG_CODE);
    // Accept looks only at the branch this word is routed to.
    assign in_a    = sel_tag ? tag_push_a : bd_push_a;

    bd_tag_split_fifo #(.W(BD_W)) u_bd_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push_v (in_v & ~sel_tag),
        .push_d ({in_payload, in_leaf_code}),
        .push_a (bd_push_a),
        .pop_v  (bd_out_v),
        .pop_d  (bd_head),
        .pop_a  (bd_out_a)
    );

    bd_tag_split_fifo #(.W(TAG_W)) u_tag_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push_v (in_v & sel_tag),
        .push_d ({in_payload[NBDData-1 -: Ntag], in_payload[Nct-1:0]}),
        .push_a (tag_push_a),
        .pop_v  (tag_out_v),
        .pop_d  (tag_head),
        .pop_a  (tag_out_a)
    );

    assign {bd_out_payload, bd_out_leaf_code} = bd_head;
    assign {tag_out_tag, tag_out_ct}          = tag_head;

    // Branch 0 = BD, branch 1 = tag/ct.
    assign xfer[0] = bd_out_v & bd_out_a;
    assign xfer[1] = tag_out_v & tag_out_a;

    for (genvar b = 0; b < 2; b++) begin : g_cnt
        bd_tag_split_cnt #(.N(Ncnt)) u_cnt (
            .clk   (clk),
            .rst_n (reset),
            .clear (cnt_clear),
            .inc   (xfer[b]),
            .count (cnt[b])
        );
    end

    assign bd_count  = cnt[0];
    assign tag_count = cnt[1];
endmodule

// File: tb/tb_bd_tag_split.sv
// Scoreboard bench for bd_tag_split: driver queues expected words on accept,
// an independent monitor pops and compares on every output transfer.

module tb_bd_tag_split;
    logic        clk;
    logic        reset;
    logic        in_v;
    logic [19:0] in_payload;
    logic [5:0]  in_leaf_code;
    logic        in_a;
    logic        bd_out_v;
    logic [19:0] bd_out_payload;
    logic [5:0]  bd_out_leaf_code;
    logic        bd_out_a;
    logic        tag_out_v;
    logic [10:0] tag_out_tag;
    logic [8:0]  tag_out_ct;
    logic        tag_out_a;
    logic        cnt_clear;
    logic [15:0] bd_count;
    logic [15:0] tag_count;

    logic        s_in_v;
    logic [19:0] s_in_payload;
    logic [5:0]  s_in_leaf_code;
    logic        s_in_a;
    logic        s_bd_out_v;
    logic [19:0] s_bd_out_payload;
    logic [5:0]  s_bd_out_leaf_code;
    logic        s_bd_out_a;
    logic        s_tag_out_v;
    logic [10:0] s_tag_out_tag;
    logic [8:0]  s_tag_out_ct;
    logic        s_tag_out_a;
    logic        s_cnt_clear;
    logic [3:0]  s_bd_count;
    logic [3:0]  s_tag_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [25:0] q_bd[$];
    logic [19:0] q_tag[$];

    bd_tag_split dut (
        .clk(clk), .reset(reset),
        .in_v(in_v), .in_payload(in_payload), .in_leaf_code(in_leaf_code), .in_a(in_a),
        .bd_out_v(bd_out_v), .bd_out_payload(bd_out_payload),
        .bd_out_leaf_code(bd_out_leaf_code), .bd_out_a(bd_out_a),
        .tag_out_v(tag_out_v), .tag_out_tag(tag_out_tag), .tag_out_ct(tag_out_ct),
        .tag_out_a(tag_out_a), .cnt_clear(cnt_clear),
        .bd_count(bd_count), .tag_count(tag_count)
    );

    bd_tag_split #(.Ncnt(4)) u_sat (
        .clk(clk), .reset(reset),
        .in_v(s_in_v), .in_payload(s_in_payload), .in_leaf_code(s_in_leaf_code), .in_a(s_in_a),
        .bd_out_v(s_bd_out_v), .bd_out_payload(s_bd_out_payload),
        .bd_out_leaf_code(s_bd_out_leaf_code), .bd_out_a(s_bd_out_a),
        .tag_out_v(s_tag_out_v), .tag_out_tag(s_tag_out_tag), .tag_out_ct(s_tag_out_ct),
        .tag_out_a(s_tag_out_a), .cnt_clear(s_cnt_clear),
        .bd_count(s_bd_count), .tag_count(s_tag_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one word; returns just after the accepting edge, counting stalled cycles.
    task automatic send(input logic [19:0] p, input logic [5:0] c, output int stalls);
        logic acc;
        stalls = 0;
        @(negedge clk);
        in_v = 1'b1; in_payload = p; in_leaf_code = c;
        for (int k = 0; ; k++) begin
            #4;
            acc = in_a;
            if (acc) begin
                if (c == 6'd30) q_tag.push_back({p[19:9], p[8:0]});
                else            q_bd.push_back({p, c});
            end
            @(posedge clk);
            #1;
            if (acc) break;
            if (k == 200) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: word %h never accepted", p);
                break;
            end
            stalls++;
            @(negedge clk);
        end
        in_v = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            if (q_bd.size() == 0 && q_tag.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_pending", q_bd.size() + q_tag.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares on each transfer, sampled just before the edge.
    always @(negedge clk) begin
        logic [25:0] eb;
        logic [19:0] et;
        #4;
        if (reset && bd_out_v && bd_out_a) begin
            n_cmp++;
            if (q_bd.size() == 0) begin
                n_err++;
                $display("FAIL bd_unexpected: got %h/%0d with nothing expected", bd_out_payload, bd_out_leaf_code);
            end else begin
                eb = q_bd.pop_front();
                if ({bd_out_payload, bd_out_leaf_code} !== eb) begin
                    n_err++;
                    $display("FAIL bd_word: got %h/%0d expected %h/%0d",
                             bd_out_payload, bd_out_leaf_code, eb[25:6], eb[5:0]);
                end
            end
        end
        if (reset && tag_out_v && tag_out_a) begin
            n_cmp++;
            if (q_tag.size() == 0) begin
                n_err++;
                $display("FAIL tag_unexpected: got tag %h ct %h with nothing expected", tag_out_tag, tag_out_ct);
            end else begin
                et = q_tag.pop_front();
                if ({tag_out_tag, tag_out_ct} !== et) begin
                    n_err++;
                    $display("FAIL tag_word: got tag %h ct %h expected tag %h ct %h",
                             tag_out_tag, tag_out_ct, et[19:9], et[8:0]);
                end
            end
        end
    end

    initial begin
        int st;
        int tot;
        reset = 1'b0; in_v = 1'b0; in_payload = '0; in_leaf_code = '0;
        bd_out_a = 1'b0; tag_out_a = 1'b0; cnt_clear = 1'b0;
        s_in_v = 1'b0; s_in_payload = '0; s_in_leaf_code = '0;
        s_bd_out_a = 1'b0; s_tag_out_a = 1'b0; s_cnt_clear = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_a", in_a, 1);
        chk("rst_bd_v", bd_out_v, 0);
        chk("rst_tag_v", tag_out_v, 0);
        chk("rst_counts", {bd_count, tag_count}, 0);
        chk("rst_bd_data", {bd_out_payload, bd_out_leaf_code}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single tag word: 0x0ABCD -> tag 0x055, ct 0x1CD
        bd_out_a = 1'b1; tag_out_a = 1'b1;
        send(20'h0ABCD, 6'd30, st);
        chk("t1_tag_v", tag_out_v, 1);
        chk("t1_tag", tag_out_tag, 11'h055);
        chk("t1_ct", tag_out_ct, 9'h1CD);
        chk("t1_bd_idle", bd_out_v, 0);
        @(posedge clk); #1;
        chk("t1_tag_count", tag_count, 1);

        // Single BD word
        send(20'hFFFFF, 6'd5, st);
        chk("t2_bd_v", bd_out_v, 1);
        chk("t2_payload", bd_out_payload, 20'hFFFFF);
        chk("t2_code", bd_out_leaf_code, 6'd5);
        chk("t2_tag_idle", tag_out_v, 0);
        @(posedge clk); #1;
        chk("t2_bd_count", bd_count, 1);

        // Tag branch stalled: third tag word blocks, BD word queues behind it
        tag_out_a = 1'b0;
        fork
            begin
                send(20'h11111, 6'd30, st);
                send(20'h22222, 6'd30, st);
                send(20'h33333, 6'd30, st);
                send(20'h44444, 6'd7, st);
            end
            begin
                repeat (6) @(negedge clk);
                #4;
                chk("t3_stall_in_a", in_a, 0);
                chk("t3_stall_bd_count", bd_count, 1);
                chk("t3_tag_v_held", tag_out_v, 1);
                @(negedge clk);
                tag_out_a = 1'b1;
            end
        join
        wait_drain();
        chk("t3_tag_count", tag_count, 4);
        chk("t3_bd_count", bd_count, 2);

        @(negedge clk); cnt_clear = 1'b1;
        @(negedge clk); cnt_clear = 1'b0;
        #1;
        chk("clr_counts", {bd_count, tag_count}, 0);

        // Alternating branches at full rate
        tot = 0;
        for (int i = 0; i < 100; i++) begin
            send(20'((i + 1) * 32'h1357), (i % 2 == 0) ? 6'd30 : 6'd2, st);
            tot += st;
        end
        chk("t4_stalls", tot, 0);
        wait_drain();
        chk("t4_bd_count", bd_count, 50);
        chk("t4_tag_count", tag_count, 50);

        // Saturation (4-bit counters) and clear vs. same-cycle transfer
        s_bd_out_a = 1'b1;
        @(negedge clk);
        s_in_v = 1'b1; s_in_payload = 20'h12345; s_in_leaf_code = 6'd5;
        repeat (3) @(negedge clk);
        #4;
        chk("sat_in_a", s_in_a, 1);
        chk("sat_bd_word", {s_bd_out_v, s_bd_out_payload, s_bd_out_leaf_code}, {1'b1, 20'h12345, 6'd5});
        repeat (17) @(negedge clk);
        s_in_v = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_bd_count", s_bd_count, 4'hF);
        chk("sat_tag_side", {s_tag_out_v, s_tag_out_tag, s_tag_out_ct, s_tag_count}, 0);
        s_in_v = 1'b1;
        @(negedge clk);
        s_in_v = 1'b0; s_cnt_clear = 1'b1;
        #1;
        chk("sat_clr_pre_v", s_bd_out_v, 1);
        @(negedge clk);
        s_cnt_clear = 1'b0;
        #1;
        chk("sat_clr_wins", s_bd_count, 0);

        // Asynchronous reset with two words buffered per branch
        bd_out_a = 1'b0; tag_out_a = 1'b0;
        send(20'hA0001, 6'd30, st);
        send(20'hB0002, 6'd9, st);
        send(20'hA0003, 6'd30, st);
        send(20'hB0004, 6'd9, st);
        chk("t6_full_in_a", in_a, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("t6_bd_v_drop", bd_out_v, 0);
        chk("t6_tag_v_drop", tag_out_v, 0);
        chk("t6_counts", {bd_count, tag_count}, 0);
        q_bd.delete(); q_tag.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bd_out_a = 1'b1; tag_out_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_replay", {bd_out_v, tag_out_v, bd_count, tag_count}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
